// File: rtl/spn_cipher_core.sv
// Iterative substitution-permutation cipher core: one round per clock, on-the-fly key schedule,
// encrypt or decrypt selected per block, valid/ready handshakes on both sides.
module spn_cipher_core #(
    parameter int unsigned NBYTES  = 4,
    parameter int unsigned NROUNDS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  global_en,
    input  logic                  mode,
    input  logic [8*NBYTES-1:0]   key,
    input  logic [8*NBYTES-1:0]   din,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [8*NBYTES-1:0]   dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [3:0]            round
);

    localparam int unsigned W         = 8 * NBYTES;
    localparam logic [3:0]  LastRound = 4'(NROUNDS - 1);
    localparam logic [3:0]  FinalKey  = 4'(NROUNDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   key_q, key_d;
    logic           mode_q, mode_d;
    logic [3:0]     round_q, round_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           out_valid_q, out_valid_d;

    // GF(2^8) multiply modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [W-1:0] sub_bytes(input logic [W-1:0] x, input logic inv);
        logic [W-1:0] o;
        logic [7:0]   b;
        o = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            b = x[i*8 +: 8];
            o[i*8 +: 8] = inv ? gf_inv(inv_affine(b)) : affine(gf_inv(b));
        end
        return o;
    endfunction

    // Byte i moves to byte (i + amt) mod NBYTES; amt must be below NBYTES.
    function automatic logic [W-1:0] rot_bytes(input logic [W-1:0] x, input int unsigned amt);
        logic [W-1:0] o;
        o = x;
        for (int k = 0; k < int'(NBYTES); k++) begin
            if (amt == k) begin
                for (int i = 0; i < int'(NBYTES); i++) begin
                    o[((i + k) % NBYTES)*8 +: 8] = x[i*8 +: 8];
                end
            end
        end
        return o;
    endfunction

    function automatic logic [W-1:0] round_key(input logic [W-1:0] k, input logic [3:0] r);
        int unsigned ri;
        ri = 32'(r);
        return rot_bytes(k, ri % NBYTES) ^ {NBYTES{8'(ri + 1)}};
    endfunction

    logic [3:0]   rk_idx;
    logic [W-1:0] rk_cur;
    logic [W-1:0] rk_fin;
    logic [W-1:0] round_out;

    // Decrypt step j consumes the round keys in reverse order.
    always_comb begin
        rk_idx    = mode_q ? (LastRound - round_q) : round_q;
        rk_cur    = round_key(key_q, rk_idx);
        rk_fin    = round_key(key_q, FinalKey);
        round_out = x_q;
        if (!mode_q) begin
            round_out = sub_bytes(x_q ^ rk_cur, 1'b0);
            if (round_q == LastRound) round_out = round_out ^ rk_fin;
            else                      round_out = rot_bytes(round_out, 1);
        end else begin
            if (round_q == 4'd0) round_out = round_out ^ rk_fin;
            else                 round_out = rot_bytes(round_out, NBYTES - 1);
            round_out = sub_bytes(round_out, 1'b1) ^ rk_cur;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        key_d       = key_q;
        mode_d      = mode_q;
        round_d     = round_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        if (global_en) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_d     = din;
                        key_d   = key;
                        mode_d  = mode;
                        round_d = 4'd0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    x_d = round_out;
                    if (round_q == LastRound) begin
                        dout_d      = round_out;
                        out_valid_d = 1'b1;
                        round_d     = 4'd0;
                        state_d     = StDone;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            x_q         <= '0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            round_q     <= 4'd0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            round_q     <= round_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && global_en;
    assign busy      = (state_q == StRun);
    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign round     = round_q;

endmodule

// File: doc/spn_cipher_core.md
Name: spn_cipher_core

Overview:
- Parametrised iterative substitution-permutation cipher core. Generalises the fixed 4-byte S-box stage to NBYTES bytes, NROUNDS rounds, an on-the-fly key schedule and selectable encrypt/decrypt mode.
- Executes one round per clock over a valid/ready stream interface.
- Sits between the plaintext/ciphertext register file and the output byte mux in the crypto datapath.

Parameters:
- NBYTES, 4: data width in bytes. W = 8*NBYTES.
- NROUNDS, 3: number of substitution rounds, 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- GLOBAL_EN  in  1  synchronous enable. When low, all state freezes.
- MODE  in  1  0 = encrypt, 1 = decrypt. Sampled on accept.
- KEY  in  W  master key. Sampled on accept.
- DIN  in  W  input block. Byte 0 = DIN[7:0].
- IN_VALID  in  1  input block valid.
- IN_READY  out  1  core can accept a block.
- DOUT  out  W  result block.
- OUT_VALID  out  1  DOUT valid.
- OUT_READY  in  1  downstream accepts DOUT.
- BUSY  out  1  high in RUN state.
- ROUND  out  4  current round index.

Behaviour:
- Interface (already decided): one clock, CLK. Reset is asynchronous and active-low, on RST_N.
- Reset values: state IDLE; DOUT = 0; OUT_VALID = 0; BUSY = 0; ROUND = 0. Internal state, key and mode registers are all 0.
- Round keys: K_r = ROTL_BYTES(KEY_reg, r mod NBYTES) XOR {NBYTES{8'(r+1)}}, for r = 0..NROUNDS.
- S is the AES S-box and S^-1 its inverse, applied bytewise.
- ROTL/ROTR_BYTES(x,1) move byte i to byte i+1 (ROTL) or byte i-1 (ROTR), modulo NBYTES.
- Encrypt, round r = ROUND (0..NROUNDS-1): x = S(x ^ K_r). If r < NROUNDS-1, x = ROTL_BYTES(x,1). If r = NROUNDS-1, x = x ^ K_NROUNDS.
- Decrypt, step j = ROUND, with r = NROUNDS-1-j:
  - If j = 0, x = x ^ K_NROUNDS first.
  - If r < NROUNDS-1, x = ROTR_BYTES(x,1).
  - Then x = S^-1(x) ^ K_r.
  - Decrypt is the exact inverse of encrypt.
- FSM state IDLE: IN_READY = GLOBAL_EN. When IN_VALID & IN_READY, latch DIN into x, and latch KEY and MODE. Set ROUND = 0 and go to RUN.
- FSM state RUN: BUSY = 1. Each enabled cycle applies one round and increments ROUND. After the round with ROUND = NROUNDS-1: DOUT <= result, OUT_VALID <= 1, ROUND <= 0, go to DONE.
- FSM state DONE: OUT_VALID is held and DOUT is stable until OUT_READY = 1. On that edge, OUT_VALID <= 0 and go to IDLE.
- Latency: with accept on edge t0, OUT_VALID rises on edge t0 + NROUNDS. Minimum spacing between accepts is NROUNDS + 2 cycles.
- IN_READY is 0 in RUN and DONE. IN_VALID is ignored there, and DIN/KEY/MODE changes there have no effect.
- GLOBAL_EN low: no register updates (FSM, ROUND, x and DOUT all hold). IN_READY = 0. OUT_VALID holds its value. An OUT_READY handshake does not complete while GLOBAL_EN is low.
- RST_N asserted mid-operation: immediate return to reset values. The in-flight block is discarded and no OUT_VALID pulse is produced.
- ROUND wraps only via the explicit clear to 0. It never exceeds NROUNDS-1.

Test Plan:
- Encrypt, defaults, KEY = 0, DIN = 32'h00000000, OUT_READY = 1 -> DOUT = 32'h88888888. OUT_VALID rises exactly 3 cycles after the accept edge and lasts 1 cycle.
- Decrypt, KEY = 0, DIN = 32'h88888888 -> DOUT = 32'h00000000. Also round-trip DIN = 32'hAAAAAAAA with KEY = 32'h01234567 through encrypt then decrypt -> 32'hAAAAAAAA.
- Back-pressure: hold OUT_READY = 0 for 5 cycles after OUT_VALID -> DOUT stable, OUT_VALID high, IN_READY low. Release -> IN_READY high the next cycle.
- GLOBAL_EN dropped for 4 cycles mid-RUN -> ROUND and BUSY frozen. Total latency extends by exactly 4 cycles and DOUT is unchanged versus the uninterrupted run.
- RST_N pulsed low during RUN, asynchronously between edges -> outputs zero immediately and no OUT_VALID afterward. A new accept after release produces the correct result.
- Parameter sweep NBYTES = 8, NROUNDS = 5 with random KEY/DIN -> decrypt(encrypt(x)) = x for 100 vectors. Latency is 5 cycles.
